// File: rtl/mem_req_seq.sv
// Request sequencer for the 8-bit memory: valid/ready requests -> FIFO -> one pin access at a time.
// Optional MEM_REQ_SEQ_STATS_EN adds saturating rd_count/wr_count outputs.
module mem_req_seq #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              read_write,
    output logic              chip_en
`ifdef MEM_REQ_SEQ_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    // Cycles left in WAIT after the first one; only meaningful when RD_LAT > 1.
    localparam logic [2:0] WAIT_INIT = 3'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PW:0]       r_wptr, r_rptr;
    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_rsp_valid, r_chip_en, r_read_write;
    logic [DATA_W-1:0] r_rsp_rdata, r_data_in;
    logic [ADDR_W-1:0] r_address;

    logic              w_empty, w_full, w_push, w_pop;
    logic [ENT_W-1:0]  w_head;
    logic              w_head_wr;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_push  = req_valid && req_ready;

    assign w_head       = r_fifo[r_rptr[PW-1:0]];
    assign w_head_wr    = w_head[ENT_W-1];
    assign w_head_addr  = w_head[ENT_W-2 -: ADDR_W];
    assign w_head_wdata = w_head[DATA_W-1:0];

    // A new access starts from IDLE, or back-to-back right behind a write in ISSUE.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_ISSUE) && !r_read_write));

    assign req_ready  = !w_full && !rst;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign address    = r_address;
    assign data_in    = r_data_in;
    assign read_write = r_read_write;
    assign chip_en    = r_chip_en;

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr[PW-1:0]] <= {req_write, req_addr, req_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_address    <= '0;
            r_data_in    <= '0;
            r_read_write <= 1'b1;
            r_chip_en    <= 1'b0;
        end else begin
            r_chip_en <= w_pop;
            if (w_pop) begin
                r_address    <= w_head_addr;
                r_read_write <= !w_head_wr;
                if (w_head_wr) r_data_in <= w_head_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (!r_read_write) begin
                        if (!w_pop) r_state <= S_IDLE;
                    end else if (RD_LAT == 1) begin
                        r_rsp_rdata <= data_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt   <= WAIT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_rsp_rdata <= data_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_REQ_SEQ_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            if (r_read_write) begin
                if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            end else begin
                if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_cnt;
    assign wr_count = r_wr_cnt;
`endif

endmodule

// File: tb/tb_mem_req_seq.sv
// Bench for mem_req_seq: directed table, latency/reset sequences, and random traffic
// checked against a queue-based model of in-order accesses and read responses.
module tb_mem_req_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_write, rsp_ready, req_ready, rsp_valid, busy, read_write, chip_en;
    logic [7:0] req_addr, req_wdata, rsp_rdata, address, data_in, data_out;

    logic       rst3, v3, w3, rr3, rdy3, rv3, busy3, rw3, ce3;
    logic [7:0] a3, d3, rd3, addr3, din3, dout3;

`ifdef MEM_REQ_SEQ_STATS_EN
    logic [15:0] rd_count, wr_count, rd_count3, wr_count3;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_req_seq #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .address(address), .data_in(data_in), .data_out(data_out),
        .read_write(read_write), .chip_en(chip_en)
`ifdef MEM_REQ_SEQ_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    mem_req_seq #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .FIFO_DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3),
        .req_write(w3), .req_addr(a3), .req_wdata(d3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_rdata(rd3),
        .busy(busy3), .address(addr3), .data_in(din3), .data_out(dout3),
        .read_write(rw3), .chip_en(ce3)
`ifdef MEM_REQ_SEQ_STATS_EN
        , .rd_count(rd_count3), .wr_count(wr_count3)
`endif
    );

    // Memory behind dut: write on a write pulse, read data visible only during a read pulse.
    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clk) if (chip_en && !read_write) mem[address] <= data_in;
    assign data_out = (chip_en && read_write) ? mem[address] : 8'hEE;

    // rsp_ready is either driven by the test or randomised each cycle.
    logic rr_mode = 1'b0, rr_man = 1'b1, rr_rnd = 1'b1;
    always @(posedge clk) begin
        #1 rr_rnd = ($urandom_range(0, 3) != 0);
    end
    assign rsp_ready = rr_mode ? rr_rnd : rr_man;

    // Reference model: accepted requests must appear on the pins in order; each read
    // returns the value of the last earlier write to that address.
    typedef struct { logic w; logic [7:0] a; logic [7:0] d; } acc_t;
    acc_t       acc_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    int n_acc = 0, n_iss = 0, n_rsp = 0, n_rd_acc = 0, n_wr_acc = 0;

    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            exp_q.delete();
            n_acc = 0;
            n_iss = 0;
        end else begin
            if (chip_en) begin
                n_iss++;
                n_vec++;
                if (acc_q.size() == 0) begin
                    n_err++;
                    $display("FAIL access_order: unexpected chip_en at addr %h", address);
                end else begin
                    acc_t e;
                    e = acc_q.pop_front();
                    if (read_write !== !e.w || address !== e.a || (e.w && data_in !== e.d)) begin
                        n_err++;
                        $display("FAIL access_pins: got rw=%b addr=%h din=%h expected rw=%b addr=%h din=%h",
                                 read_write, address, data_in, !e.w, e.a, e.d);
                    end
                end
            end
            n_vec++;
            if (req_ready !== ((n_acc - n_iss) < DEPTH)) begin
                n_err++;
                $display("FAIL req_ready: got %b with %0d queued, depth %0d", req_ready, n_acc - n_iss, DEPTH);
            end
            if (req_valid && req_ready) begin
                n_acc++;
                acc_q.push_back('{w: req_write, a: req_addr, d: req_wdata});
                if (req_write) begin
                    ref_mem[req_addr] = req_wdata;
                    n_wr_acc++;
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                    n_rd_acc++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_vec++;
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_spurious: got rdata %h with no read outstanding", rsp_rdata);
                end else begin
                    logic [7:0] x;
                    x = exp_q.pop_front();
                    if (rsp_rdata !== x) begin
                        n_err++;
                        $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, x);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; returns ok=1 if the request was accepted within limit cycles.
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int limit, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && acc_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk(nm, 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic v, w;
        logic [7:0] a, d;
        logic [7:0] e_addr, e_din;
        logic [4:0] e_flags;   // {chip_en, read_write, rsp_valid, req_ready, busy}
        logic [7:0] e_rd;
    } vec_t;

    function automatic vec_t mk(logic v, logic w, logic [7:0] a, logic [7:0] d,
                                logic [7:0] ea, logic [7:0] ed, logic [4:0] ef, logic [7:0] er);
        vec_t t;
        t.v = v; t.w = w; t.a = a; t.d = d;
        t.e_addr = ea; t.e_din = ed; t.e_flags = ef; t.e_rd = er;
        return t;
    endfunction

    vec_t tbl [13];

    initial begin
        bit ok;
        int acc_cnt, rsp0;
        logic [28:0] got, want;
        logic stale;

        tbl[0]  = mk(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00, 8'h00, 5'b01010, 8'h00);
        tbl[1]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00, 5'b01011, 8'h00);
        tbl[2]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'hA5, 5'b10011, 8'h00);
        tbl[3]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'hA5, 5'b11011, 8'h00);
        tbl[4]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'hA5, 5'b01111, 8'hA5);
        tbl[5]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'hA5, 5'b01010, 8'hA5);
        tbl[6]  = mk(1'b1, 1'b1, 8'h20, 8'h01, 8'h10, 8'hA5, 5'b01010, 8'hA5);
        tbl[7]  = mk(1'b1, 1'b1, 8'h21, 8'h02, 8'h10, 8'hA5, 5'b01011, 8'hA5);
        tbl[8]  = mk(1'b1, 1'b1, 8'h22, 8'h03, 8'h20, 8'h01, 5'b10011, 8'hA5);
        tbl[9]  = mk(1'b1, 1'b1, 8'h23, 8'h04, 8'h21, 8'h02, 5'b10011, 8'hA5);
        tbl[10] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h22, 8'h03, 5'b10011, 8'hA5);
        tbl[11] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h23, 8'h04, 5'b10011, 8'hA5);
        tbl[12] = mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h23, 8'h04, 5'b00010, 8'hA5);

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        rst3 = 1'b1; v3 = 1'b0; w3 = 1'b0; a3 = 8'h00; d3 = 8'h00; rr3 = 1'b0; dout3 = 8'hEE;

        repeat (2) @(posedge clk);
        #1;
        // {req_ready, rsp_valid, rsp_rdata, busy, address, data_in, read_write, chip_en}
        chk("reset_state", 32'({req_ready, rsp_valid, rsp_rdata, busy, address, data_in, read_write, chip_en}),
            32'({1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0}));

        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            req_valid = tbl[i].v; req_write = tbl[i].w; req_addr = tbl[i].a; req_wdata = tbl[i].d;
            @(negedge clk);
            got  = {address, data_in, chip_en, read_write, rsp_valid, req_ready, busy, rsp_rdata};
            want = {tbl[i].e_addr, tbl[i].e_din, tbl[i].e_flags, tbl[i].e_rd};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL table[%0d]: got %h expected %h", i, got, want);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;

        // Backpressure: first read parks in RESP, four more fill the FIFO, the sixth stalls.
        rr_man = 1'b0;
        rsp0 = n_rsp;
        acc_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            send(1'b0, 8'h30 + 8'(k), 8'h00, 6, ok);
            if (ok) acc_cnt++;
        end
        chk("bp_accepted", 32'(acc_cnt), 32'd5);
        @(negedge clk);
        chk("bp_ready_low", 32'({req_ready, rsp_valid}), 32'({1'b0, 1'b1}));
        @(posedge clk); #1;
        rr_man = 1'b1;
        send(1'b0, 8'h35, 8'h00, 20, ok);
        chk("bp_sixth_accepted", 32'(ok), 32'd1);
        drain("bp_drain");
        chk("bp_rsp_count", 32'(n_rsp - rsp0), 32'd6);

        // Random traffic on a small address window to exercise read-after-write ordering.
        rr_mode = 1'b1;
        for (int t = 0; t < 300; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(($urandom_range(0, 9) < 4), 8'h40 + 8'($urandom_range(0, 7)), 8'($urandom), 200, ok);
            if (!ok) begin
                n_vec++; n_err++;
                $display("FAIL rand_send_timeout: got no accept expected accept at txn %0d", t);
            end
        end
        drain("rand_drain");
        rr_mode = 1'b0;

`ifdef MEM_REQ_SEQ_STATS_EN
        chk("wr_count", 32'(wr_count), 32'(n_wr_acc));
        chk("rd_count", 32'(rd_count), 32'(n_rd_acc));
        force dut.r_wr_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.r_wr_cnt;
        send(1'b1, 8'h50, 8'h77, 20, ok);
        drain("sat_drain");
        chk("wr_count_sat", 32'(wr_count), 32'h0000FFFF);
`endif

        // RD_LAT=3: one chip_en cycle, two WAIT cycles, sample on the third edge after the pop.
        rst3 = 1'b0;
        @(negedge clk);
        chk("d3_ready", 32'({rdy3, busy3, rv3}), 32'({1'b1, 1'b0, 1'b0}));
        @(posedge clk); #1;
        v3 = 1'b1; w3 = 1'b0; a3 = 8'h22;
        @(posedge clk); #1;
        v3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            dout3 = (k == 4) ? 8'h5C : 8'hEE;
            @(negedge clk);
            chk($sformatf("d3_lat_c%0d", k), 32'({ce3, rv3, busy3}), 32'({(k == 2), (k == 5), 1'b1}));
            if (k == 2) chk("d3_pins", 32'({addr3, rw3}), 32'({8'h22, 1'b1}));
            if (k == 5) chk("d3_rdata", 32'(rd3), 32'h5C);
            @(posedge clk); #1;
        end
        dout3 = 8'hEE;
        rr3 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("d3_rsp_done", 32'({rv3, busy3}), 32'({1'b0, 1'b0}));
        @(posedge clk); #1;

        // Reset during WAIT with two reads still queued.
        v3 = 1'b1; a3 = 8'h30;
        @(posedge clk); #1; a3 = 8'h31;
        @(posedge clk); #1; a3 = 8'h32;
        @(posedge clk); #1; v3 = 1'b0;
        @(negedge clk);
        chk("d3_in_wait", 32'({ce3, busy3, rv3}), 32'({1'b0, 1'b1, 1'b0}));
        rst3 = 1'b1;
        #1;
        chk("d3_rst_async", 32'({ce3, busy3, rdy3, rv3}), 32'({1'b0, 1'b0, 1'b0, 1'b0}));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("d3_ready_after_rst", 32'(rdy3), 32'd1);
        stale = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rv3 || ce3 || busy3) stale = 1'b1;
        end
        chk("d3_no_stale", 32'(stale), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
